// File: rtl/pcgen_pkg.sv
// rtl/pcgen_pkg.sv - shared constants, counter encodings and helpers for the PC generator / BTB
package pcgen_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int BTB_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Two-bit saturating counter step toward ST on taken, toward SNT on not-taken
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken && ctr != CTR_ST) begin
      r = ctr + 2'd1;
    end else if (!taken && ctr != CTR_SNT) begin
      r = ctr - 2'd1;
    end
    return r;
  endfunction

  // A counter predicts taken when its upper bit is set (WT or ST)
  function automatic logic ctr_taken(input logic [1:0] ctr);
    return (ctr == CTR_WT) || (ctr == CTR_ST);
  endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - BTB storage: valid/tag/target/counter arrays, lookup and update-side reads, one write port
module btb_array
  import pcgen_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [ADDR_W-1:0] rtgt,
  output logic [1:0]        rctr,
  input  logic [IDX_W-1:0]  uidx,
  output logic              uvalid,
  output logic [TAG_W-1:0]  utag,
  output logic [ADDR_W-1:0] utgt,
  output logic [1:0]        uctr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [ADDR_W-1:0] wtgt,
  input  logic [1:0]        wctr,
  input  logic              wvalid
);

  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tag [DEPTH];
  logic [ADDR_W-1:0] tgt [DEPTH];
  logic [1:0]        ctr [DEPTH];

  // Fetch-side lookup and ID-side update read are both asynchronous; they see pre-edge contents
  assign rvalid = valid[ridx];
  assign rtag   = tag[ridx];
  assign rtgt   = tgt[ridx];
  assign rctr   = ctr[ridx];
  assign uvalid = valid[uidx];
  assign utag   = tag[uidx];
  assign utgt   = tgt[uidx];
  assign uctr   = ctr[uidx];

  // Valid bits and counters carry reset state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_WNT;
      end
    end else if (we) begin
      valid[widx] <= wvalid;
      ctr[widx]   <= wctr;
    end
  end

  // Tag and target are only meaningful behind a set valid bit, so they need no reset
  always_ff @(posedge clk) begin
    if (we) begin
      tag[widx] <= wtag;
      tgt[widx] <= wtgt;
    end
  end

endmodule

// File: rtl/pc_gen_btb.sv
// rtl/pc_gen_btb.sv - fetch PC register, BTB prediction, ID-stage resolve and misprediction redirect
module pc_gen_btb
  import pcgen_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                BTB_DEPTH = BTB_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              Clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic              Valid_ID,
  input  logic [ADDR_W-1:0] PC_ID,
  input  logic              Pred_taken_ID,
  input  logic [ADDR_W-1:0] Pred_target_ID,
  input  logic              Branch_ID,
  input  logic              Branch_result_ID,
  input  logic              Jump_ID,
  input  logic              JumptoReg_ID,
  input  logic [25:0]       IR_ID,
  input  logic [ADDR_W-3:0] PC_Sign_extended_ID,
  input  logic [ADDR_W-1:0] JumpReg_addr_ID,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC_IF,
  output logic              Pred_taken_IF,
  output logic [ADDR_W-1:0] Pred_target_IF,
  output logic              Flush_IF
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;

  logic [IDX_W-1:0]  l_idx;
  logic [TAG_W-1:0]  l_tag;
  logic              l_valid;
  logic [TAG_W-1:0]  l_tag_rd;
  logic [ADDR_W-1:0] l_tgt;
  logic [1:0]        l_ctr;

  logic [ADDR_W-3:0] ia_word;
  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              u_valid;
  logic [TAG_W-1:0]  u_tag_rd;
  logic [ADDR_W-1:0] u_tgt;
  logic [1:0]        u_ctr;
  logic              u_hit;

  logic              is_jr, is_j, is_br;
  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              mispredict;

  logic              we, wvalid;
  logic [TAG_W-1:0]  wtag;
  logic [ADDR_W-1:0] wtgt;
  logic [1:0]        wctr;

  // Only the word part of the address advances; the byte offset rides along
  assign PC    = pc_q;
  assign PC_IF = {pc_q[ADDR_W-1:2] + WORD_ONE, pc_q[1:0]};

  assign l_idx = pc_q[IDX_W+1:2];
  assign l_tag = pc_q[ADDR_W-1:IDX_W+2];

  assign Pred_taken_IF  = l_valid && (l_tag_rd == l_tag) && ctr_taken(l_ctr);
  assign Pred_target_IF = Pred_taken_IF ? l_tgt : PC_IF;

  // PC_ID is the fall-through address, so the instruction itself lives one word lower
  assign ia_word = PC_ID[ADDR_W-1:2] - WORD_ONE;
  assign u_idx   = ia_word[IDX_W-1:0];
  assign u_tag   = ia_word[ADDR_W-3:IDX_W];
  assign u_hit   = u_valid && (u_tag_rd == u_tag);

  assign is_jr = Valid_ID && JumptoReg_ID;
  assign is_j  = Valid_ID && !JumptoReg_ID && Jump_ID;
  assign is_br = Valid_ID && !JumptoReg_ID && !Jump_ID && Branch_ID;
  assign taken = is_jr || is_j || (is_br && Branch_result_ID);

  // Resolved target with JR over J over branch priority
  always_comb begin
    target = {PC_ID[ADDR_W-1:2] + PC_Sign_extended_ID, PC_ID[1:0]};
    if (JumptoReg_ID) begin
      target = JumpReg_addr_ID;
    end else if (Jump_ID) begin
      target = {PC_ID[ADDR_W-1:28], IR_ID, 2'b00};
    end
  end

  // A predicted-taken non-control instruction also counts as a mispredict
  assign mispredict = Valid_ID && ((taken != Pred_taken_ID) || (taken && (target != Pred_target_ID)));
  assign Flush_IF   = mispredict && !Stall;

  // Next fetch address: ID correction wins over the IF prediction
  always_comb begin
    next_pc = Pred_target_IF;
    if (mispredict) begin
      next_pc = taken ? target : PC_ID;
    end
  end

  // Fetch PC register; stall freezes it and drops any redirect for this cycle
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (!Stall) begin
      pc_q <= next_pc;
    end
  end

  // BTB write control for the instruction resolving in ID
  always_comb begin
    we     = 1'b0;
    wvalid = 1'b0;
    wtag   = u_tag;
    wtgt   = u_tgt;
    wctr   = u_ctr;
    if (!Stall && Valid_ID) begin
      if (is_br || is_j) begin
        if (u_hit) begin
          we     = 1'b1;
          wvalid = 1'b1;
          wctr   = ctr_next(u_ctr, taken);
          if (taken) begin
            wtgt = target;
          end
        end else if (taken) begin
          we     = 1'b1;
          wvalid = 1'b1;
          wtgt   = target;
          wctr   = CTR_WT;
        end
      end else if (u_hit) begin
        // JR targets are not stable enough to cache, and a non-control hit is a stale alias
        we     = 1'b1;
        wvalid = 1'b0;
      end
    end
  end

  btb_array #(
    .DEPTH  (BTB_DEPTH),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .ADDR_W (ADDR_W)
  ) u_btb (
    .clk    (Clk),
    .rst_n  (rst_n),
    .ridx   (l_idx),
    .rvalid (l_valid),
    .rtag   (l_tag_rd),
    .rtgt   (l_tgt),
    .rctr   (l_ctr),
    .uidx   (u_idx),
    .uvalid (u_valid),
    .utag   (u_tag_rd),
    .utgt   (u_tgt),
    .uctr   (u_ctr),
    .we     (we),
    .widx   (u_idx),
    .wtag   (wtag),
    .wtgt   (wtgt),
    .wctr   (wctr),
    .wvalid (wvalid)
  );

endmodule

// File: tb/tb_pc_gen_btb.sv
// tb/tb_pc_gen_btb.sv - directed scenarios plus randomized run against a behavioural fetch/BTB model
module tb_pc_gen_btb;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        Valid_ID;
  logic [31:0] PC_ID;
  logic        Pred_taken_ID;
  logic [31:0] Pred_target_ID;
  logic        Branch_ID;
  logic        Branch_result_ID;
  logic        Jump_ID;
  logic        JumptoReg_ID;
  logic [25:0] IR_ID;
  logic [29:0] PC_Sign_extended_ID;
  logic [31:0] JumpReg_addr_ID;
  logic [31:0] PC;
  logic [31:0] PC_IF;
  logic        Pred_taken_IF;
  logic [31:0] Pred_target_IF;
  logic        Flush_IF;

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;

  always #5 Clk = ~Clk;

  pc_gen_btb dut (
    .Clk                 (Clk),
    .rst_n               (rst_n),
    .Stall               (Stall),
    .Valid_ID            (Valid_ID),
    .PC_ID               (PC_ID),
    .Pred_taken_ID       (Pred_taken_ID),
    .Pred_target_ID      (Pred_target_ID),
    .Branch_ID           (Branch_ID),
    .Branch_result_ID    (Branch_result_ID),
    .Jump_ID             (Jump_ID),
    .JumptoReg_ID        (JumptoReg_ID),
    .IR_ID               (IR_ID),
    .PC_Sign_extended_ID (PC_Sign_extended_ID),
    .JumpReg_addr_ID     (JumpReg_addr_ID),
    .PC                  (PC),
    .PC_IF               (PC_IF),
    .Pred_taken_IF       (Pred_taken_IF),
    .Pred_target_IF      (Pred_target_IF),
    .Flush_IF            (Flush_IF)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bubble();
    Valid_ID = 1'b0; PC_ID = '0; Pred_taken_ID = 1'b0; Pred_target_ID = '0;
    Branch_ID = 1'b0; Branch_result_ID = 1'b0; Jump_ID = 1'b0; JumptoReg_ID = 1'b0;
    IR_ID = '0; PC_Sign_extended_ID = '0; JumpReg_addr_ID = '0;
  endtask

  task automatic drive_br(input logic [31:0] pc_id, input logic pt, input logic [31:0] ptgt,
                          input logic res, input int off);
    bubble();
    Valid_ID = 1'b1; PC_ID = pc_id; Pred_taken_ID = pt; Pred_target_ID = ptgt;
    Branch_ID = 1'b1; Branch_result_ID = res; PC_Sign_extended_ID = 30'(off);
  endtask

  task automatic drive_j(input logic [31:0] pc_id, input logic pt, input logic [31:0] ptgt,
                         input logic [25:0] ir);
    bubble();
    Valid_ID = 1'b1; PC_ID = pc_id; Pred_taken_ID = pt; Pred_target_ID = ptgt;
    Jump_ID = 1'b1; IR_ID = ir;
  endtask

  task automatic drive_jr(input logic [31:0] pc_id, input logic pt, input logic [31:0] ptgt,
                          input logic [31:0] tgt);
    bubble();
    Valid_ID = 1'b1; PC_ID = pc_id; Pred_taken_ID = pt; Pred_target_ID = ptgt;
    JumptoReg_ID = 1'b1; JumpReg_addr_ID = tgt;
  endtask

  task automatic drive_plain(input logic [31:0] pc_id, input logic pt, input logic [31:0] ptgt);
    bubble();
    Valid_ID = 1'b1; PC_ID = pc_id; Pred_taken_ID = pt; Pred_target_ID = ptgt;
  endtask

  // Force fetch to addr with a JR resolved in ID from an address whose BTB slot is never used
  task automatic redirect(input logic [31:0] addr);
    drive_jr(32'h0000_0104, 1'b0, 32'h0000_0104, addr);
    tick();
    bubble();
    #1;
  endtask

  task automatic test_reset();
    Stall = 1'b0;
    bubble();
    rst_n = 1'b0;
    #12;
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
    checks++; if (PC_IF !== 32'h4) begin failures++; $display("FAIL reset_pc_if got=%h exp=%h", PC_IF, 32'h4); end
    @(negedge Clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (PC !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, PC, 32'(4 * i)); end
      checks++; if (Pred_taken_IF !== 1'b0) begin failures++; $display("FAIL seq_pred%0d got=%b exp=0", i, Pred_taken_IF); end
      checks++; if (Flush_IF !== 1'b0) begin failures++; $display("FAIL seq_flush%0d got=%b exp=0", i, Flush_IF); end
      tick();
    end
  endtask

  task automatic test_branch_alloc();
    #1;
    checks++; if (PC !== 32'h10) begin failures++; $display("FAIL alloc_fetch_pc got=%h exp=%h", PC, 32'h10); end
    checks++; if (Pred_taken_IF !== 1'b0) begin failures++; $display("FAIL alloc_first_pred got=%b exp=0", Pred_taken_IF); end
    tick();
    drive_br(32'h14, 1'b0, 32'h14, 1'b1, 3);
    #1;
    checks++; if (Flush_IF !== 1'b1) begin failures++; $display("FAIL alloc_flush got=%b exp=1", Flush_IF); end
    tick();
    bubble();
    checks++; if (PC !== 32'h20) begin failures++; $display("FAIL alloc_redirect got=%h exp=%h", PC, 32'h20); end
  endtask

  task automatic test_predict_taken();
    redirect(32'h10);
    checks++; if (Pred_taken_IF !== 1'b1) begin failures++; $display("FAIL hit_pred got=%b exp=1", Pred_taken_IF); end
    checks++; if (Pred_target_IF !== 32'h20) begin failures++; $display("FAIL hit_target got=%h exp=%h", Pred_target_IF, 32'h20); end
    tick();
    checks++; if (PC !== 32'h20) begin failures++; $display("FAIL hit_follow got=%h exp=%h", PC, 32'h20); end
    drive_br(32'h14, 1'b1, 32'h20, 1'b1, 3);
    #1;
    checks++; if (Flush_IF !== 1'b0) begin failures++; $display("FAIL hit_no_flush got=%b exp=0", Flush_IF); end
    tick();
    bubble();
    checks++; if (PC !== 32'h24) begin failures++; $display("FAIL hit_next got=%h exp=%h", PC, 32'h24); end
  endtask

  task automatic test_not_taken_twice();
    for (int k = 0; k < 2; k++) begin
      redirect(32'h10);
      checks++; if (Pred_taken_IF !== 1'b1) begin failures++; $display("FAIL nt_pred%0d got=%b exp=1", k, Pred_taken_IF); end
      tick();
      drive_br(32'h14, 1'b1, 32'h20, 1'b0, 3);
      #1;
      checks++; if (Flush_IF !== 1'b1) begin failures++; $display("FAIL nt_flush%0d got=%b exp=1", k, Flush_IF); end
      tick();
      bubble();
      checks++; if (PC !== 32'h14) begin failures++; $display("FAIL nt_redirect%0d got=%h exp=%h", k, PC, 32'h14); end
    end
    redirect(32'h10);
    checks++; if (Pred_taken_IF !== 1'b0) begin failures++; $display("FAIL nt_third_pred got=%b exp=0", Pred_taken_IF); end
    checks++; if (Pred_target_IF !== 32'h14) begin failures++; $display("FAIL nt_third_target got=%h exp=%h", Pred_target_IF, 32'h14); end
  endtask

  task automatic test_stall();
    tick();
    drive_br(32'h14, 1'b0, 32'h14, 1'b1, 3);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (PC !== 32'h14) begin failures++; $display("FAIL stall_pc%0d got=%h exp=%h", k, PC, 32'h14); end
      checks++; if (Flush_IF !== 1'b0) begin failures++; $display("FAIL stall_flush%0d got=%b exp=0", k, Flush_IF); end
      tick();
    end
    Stall = 1'b0;
    #1;
    checks++; if (Flush_IF !== 1'b1) begin failures++; $display("FAIL stall_release_flush got=%b exp=1", Flush_IF); end
    tick();
    bubble();
    checks++; if (PC !== 32'h20) begin failures++; $display("FAIL stall_release_pc got=%h exp=%h", PC, 32'h20); end
    // Counter went 01->10 only once; one not-taken must bring it back below the taken threshold
    redirect(32'h10);
    tick();
    drive_br(32'h14, 1'b1, 32'h20, 1'b0, 3);
    tick();
    bubble();
    redirect(32'h10);
    checks++; if (Pred_taken_IF !== 1'b0) begin failures++; $display("FAIL stall_no_btb_write got=%b exp=0", Pred_taken_IF); end
    tick();
    drive_br(32'h14, 1'b0, 32'h14, 1'b1, 3);
    tick();
    bubble();
  endtask

  task automatic test_alias_jr();
    redirect(32'h10);
    checks++; if (Pred_taken_IF !== 1'b1) begin failures++; $display("FAIL alias_pre_pred got=%b exp=1", Pred_taken_IF); end
    tick();
    drive_plain(32'h14, 1'b1, 32'h20);
    #1;
    checks++; if (Flush_IF !== 1'b1) begin failures++; $display("FAIL alias_flush got=%b exp=1", Flush_IF); end
    tick();
    checks++; if (PC !== 32'h14) begin failures++; $display("FAIL alias_redirect got=%h exp=%h", PC, 32'h14); end
    drive_jr(32'h18, 1'b0, 32'h18, 32'h400);
    #1;
    checks++; if (Flush_IF !== 1'b1) begin failures++; $display("FAIL jr_flush got=%b exp=1", Flush_IF); end
    tick();
    bubble();
    checks++; if (PC !== 32'h400) begin failures++; $display("FAIL jr_target got=%h exp=%h", PC, 32'h400); end
    redirect(32'h10);
    checks++; if (Pred_taken_IF !== 1'b0) begin failures++; $display("FAIL alias_invalidated got=%b exp=0", Pred_taken_IF); end
    redirect(32'hFFFF_FFFC);
    checks++; if (PC_IF !== 32'h0) begin failures++; $display("FAIL wrap_pc_if got=%h exp=%h", PC_IF, 32'h0); end
    tick();
    checks++; if (PC !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", PC, 32'h0); end
  endtask

  // Program image: the instruction kind and its fields are fixed functions of the address
  function automatic int kind_of(input logic [31:0] ia);
    logic [31:0] h;
    h = (ia >> 2) * 32'h9E37_79B1;
    return int'(h[31:29]);
  endfunction

  function automatic int off_of(input logic [31:0] ia);
    return int'(ia[7:4]) - 8;
  endfunction

  function automatic logic [25:0] ir_of(input logic [31:0] ia);
    return {18'b0, ia[9:2] ^ ia[17:10]};
  endfunction

  function automatic logic [31:0] jr_of(input logic [31:0] ia);
    return {22'b0, ia[11:4] ^ 8'h5A, 2'b00};
  endfunction

  task automatic test_random();
    bit          m_v [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ctr [16];
    logic [31:0] m_pc, m_pcif, m_ptgt, ia, target, nxt;
    logic        m_pt, taken, mis, id_v, id_pt, stall;
    logic [31:0] id_pc, id_ptgt;
    int          kind, mi, ui;

    bubble();
    Stall = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_pc = 32'h0; id_v = 1'b0; id_pc = '0; id_pt = 1'b0; id_ptgt = '0;
    for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_ctr[i] = 1; m_tag[i] = '0; m_tgt[i] = '0; end

    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        bubble();
        Stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (PC !== 32'h0) begin failures++; $display("FAIL async_reset_pc got=%h exp=%h", PC, 32'h0); end
        @(posedge Clk);
        #1;
        rst_n = 1'b1;
        m_pc = 32'h0; id_v = 1'b0;
        for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_ctr[i] = 1; end
        continue;
      end

      stall = ($urandom % 8) == 0;
      ia = id_pc - 32'd4;
      kind = kind_of(ia);
      taken = 1'b0;
      target = 32'h0;
      if (!id_v) begin
        bubble();
        Branch_ID = 1'($urandom); Jump_ID = 1'($urandom); JumptoReg_ID = 1'($urandom);
        Pred_taken_ID = 1'($urandom); PC_ID = $urandom;
      end else if (kind <= 1) begin
        drive_br(id_pc, id_pt, id_ptgt, 1'($urandom), off_of(ia));
        taken = Branch_result_ID;
        target = id_pc + 32'(off_of(ia) * 4);
      end else if (kind == 2) begin
        drive_j(id_pc, id_pt, id_ptgt, ir_of(ia));
        taken = 1'b1;
        target = (id_pc & 32'hF000_0000) | ({6'b0, ir_of(ia)} << 2);
      end else if (kind == 3) begin
        drive_jr(id_pc, id_pt, id_ptgt, jr_of(ia));
        taken = 1'b1;
        target = jr_of(ia);
      end else begin
        drive_plain(id_pc, id_pt, id_ptgt);
      end
      Stall = stall;
      #1;

      mi = int'((m_pc >> 2) % 16);
      m_pt = m_v[mi] && (m_tag[mi] == m_pc[31:6]) && (m_ctr[mi] >= 2);
      m_pcif = m_pc + 32'd4;
      m_ptgt = m_pt ? m_tgt[mi] : m_pcif;
      mis = id_v && ((taken != id_pt) || (taken && (target != id_ptgt)));

      checks++; if (PC !== m_pc) begin failures++; if (fail_prints++ < 20) $display("FAIL rnd_pc it=%0d got=%h exp=%h", it, PC, m_pc); end
      checks++; if (Pred_taken_IF !== m_pt) begin failures++; if (fail_prints++ < 20) $display("FAIL rnd_pred it=%0d got=%b exp=%b", it, Pred_taken_IF, m_pt); end
      checks++; if (Pred_target_IF !== m_ptgt) begin failures++; if (fail_prints++ < 20) $display("FAIL rnd_target it=%0d got=%h exp=%h", it, Pred_target_IF, m_ptgt); end
      checks++; if (Flush_IF !== (mis && !stall)) begin failures++; if (fail_prints++ < 20) $display("FAIL rnd_flush it=%0d got=%b exp=%b", it, Flush_IF, mis && !stall); end

      if (!stall) begin
        if (id_v) begin
          ui = int'((ia >> 2) % 16);
          if (kind <= 2) begin
            if (m_v[ui] && m_tag[ui] == ia[31:6]) begin
              m_ctr[ui] = taken ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1) : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
              if (taken) m_tgt[ui] = target;
            end else if (taken) begin
              m_v[ui] = 1'b1; m_tag[ui] = ia[31:6]; m_tgt[ui] = target; m_ctr[ui] = 2;
            end
          end else if (m_v[ui] && m_tag[ui] == ia[31:6]) begin
            m_v[ui] = 1'b0;
          end
        end
        nxt = mis ? (taken ? target : id_pc) : m_ptgt;
        id_v = !mis && (($urandom % 10) != 0);
        id_pc = m_pcif; id_pt = m_pt; id_ptgt = m_ptgt;
        m_pc = nxt;
      end
      tick();
    end
    bubble();
    Stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch_alloc();
    test_predict_taken();
    test_not_taken_twice();
    test_stall();
    test_alias_jr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
